// File: rtl/ddsm_pipe_acc_if.sv
// Stream bundle for the pipelined delta-sigma accumulator.
// Control and increment flow in; accumulator, overflow and valid flow out.
interface ddsm_pipe_acc_if #(
    parameter int WIDTH = 16
);
    logic             i_clr;
    logic             i_en;
    logic [WIDTH-1:0] i_in;
    logic [WIDTH-1:0] o_acc;
    logic             o_cout;
    logic             o_valid;

    modport master (
        output i_clr, i_en, i_in,
        input  o_acc, o_cout, o_valid
    );

    modport slave (
        input  i_clr, i_en, i_in,
        output o_acc, o_cout, o_valid
    );
endinterface

// File: rtl/ddsm_pipe_acc.sv
// Pipelined first-order delta-sigma accumulator built from 4-bit segments.
// Segment carries are registered; input skew and output deskew keep samples aligned.
module ddsm_pipe_acc #(
    parameter int WIDTH = 16
) (
    input logic             i_clk,
    input logic             i_rst_n,
    ddsm_pipe_acc_if.slave  bus
);
    localparam int NSEG = WIDTH / 4;
    localparam int CW   = $clog2(NSEG + 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("ddsm_pipe_acc: WIDTH must be a multiple of 4 and at least 8");
    end

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt_q;

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_seg
        logic [3:0] op;
        logic       cin;
        logic [4:0] sum;
        logic [3:0] sum_q;
        logic       cy_q;

        if (k == 0) begin : g_head
            assign op  = bus.i_in[3:0];
            assign cin = 1'b0;
        end else begin : g_skew
            // Operand waits k edges so it meets the carry of its own sample
            logic [3:0] skew_q [k];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int j = 0; j < k; j++) skew_q[j] <= '0;
                end else if (bus.i_clr) begin
                    for (int j = 0; j < k; j++) skew_q[j] <= '0;
                end else if (bus.i_en) begin
                    skew_q[0] <= bus.i_in[4*k +: 4];
                    for (int j = 1; j < k; j++) skew_q[j] <= skew_q[j-1];
                end
            end

            assign op  = skew_q[k-1];
            assign cin = g_seg[k-1].cy_q;
        end

        assign sum = {1'b0, sum_q} + {1'b0, op} + {4'b0, cin};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (bus.i_clr) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (bus.i_en) begin
                sum_q <= sum[3:0];
                cy_q  <= sum[4];
            end
        end

        if (k == NSEG - 1) begin : g_last
            assign acc[4*k +: 4] = sum_q;
        end else begin : g_deskew
            logic [3:0] dsk_q [NSEG-1-k];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int j = 0; j < NSEG-1-k; j++) dsk_q[j] <= '0;
                end else if (bus.i_clr) begin
                    for (int j = 0; j < NSEG-1-k; j++) dsk_q[j] <= '0;
                end else if (bus.i_en) begin
                    dsk_q[0] <= sum_q;
                    for (int j = 1; j < NSEG-1-k; j++) dsk_q[j] <= dsk_q[j-1];
                end
            end

            assign acc[4*k +: 4] = dsk_q[NSEG-2-k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (bus.i_clr) begin
            cnt_q <= '0;
        end else if (bus.i_en && cnt_q != CW'(NSEG)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.o_acc   = acc;
    assign bus.o_cout  = g_seg[NSEG-1].cy_q;
    assign bus.o_valid = (cnt_q == CW'(NSEG));
endmodule

// File: tb/tb_ddsm_pipe_acc.sv
// Scoreboard bench for ddsm_pipe_acc at WIDTH 8, 16 and 24 in parallel.
// An unpipelined accumulator model feeds per-width expectation queues.
module tb_ddsm_pipe_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddsm_pipe_acc_if #(.WIDTH(8))  if8  ();
    ddsm_pipe_acc_if #(.WIDTH(16)) if16 ();
    ddsm_pipe_acc_if #(.WIDTH(24)) if24 ();

    ddsm_pipe_acc #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8.slave));
    ddsm_pipe_acc #(.WIDTH(16)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(if16.slave));
    ddsm_pipe_acc #(.WIDTH(24)) dut24 (.i_clk(clk), .i_rst_n(rst_n), .bus(if24.slave));

    int errors = 0;
    int checks = 0;

    // packed as {valid, cout, acc[23:0]}
    logic [25:0] sbq [3][$];
    logic [25:0] last_exp [3];
    logic [23:0] acc_m [3];

    function automatic int wid(int i);
        return (i == 0) ? 8 : (i == 1) ? 16 : 24;
    endfunction

    function automatic logic [25:0] obs(int i);
        case (i)
            0:       return {if8.o_valid, if8.o_cout, 16'h0, if8.o_acc};
            1:       return {if16.o_valid, if16.o_cout, 8'h0, if16.o_acc};
            default: return {if24.o_valid, if24.o_cout, if24.o_acc};
        endcase
    endfunction

    task automatic check(input string tag, input logic [25:0] o,
                         input logic [25:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sbq[i].delete();
            acc_m[i] = '0;
            last_exp[i] = '0;
        end
    endtask

    task automatic step(input string tag, input bit en, input bit clr,
                        input logic [23:0] x);
        logic [24:0] s;
        logic [23:0] msk;
        logic [25:0] e;
        int w;
        if8.i_en = en;   if16.i_en = en;   if24.i_en = en;
        if8.i_clr = clr; if16.i_clr = clr; if24.i_clr = clr;
        if8.i_in = x[7:0];
        if16.i_in = x[15:0];
        if24.i_in = x;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            w = wid(i);
            msk = 24'((25'd1 << w) - 25'd1);
            if (clr) begin
                sbq[i].delete();
                acc_m[i] = '0;
            end else if (en) begin
                s = {1'b0, acc_m[i]} + {1'b0, x & msk};
                acc_m[i] = s[23:0] & msk;
                sbq[i].push_back({1'b1, s[w], acc_m[i]});
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            if (clr || en) begin
                e = '0;
                if (sbq[i].size() == wid(i) / 4) e = sbq[i].pop_front();
                check($sformatf("%s/w%0d", tag, wid(i)), obs(i), e);
                last_exp[i] = e;
            end else begin
                check($sformatf("%s_hold/w%0d", tag, wid(i)), obs(i), last_exp[i]);
            end
        end
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("%s/w%0d", tag, wid(i)), obs(i), 26'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit en;
        model_reset();
        if8.i_en = 0;  if16.i_en = 0;  if24.i_en = 0;
        if8.i_clr = 0; if16.i_clr = 0; if24.i_clr = 0;
        if8.i_in = 0;  if16.i_in = 0;  if24.i_in = 0;
        #12;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset/w%0d", wid(i)), obs(i), 26'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x4000 ramp: first valid output after the 4th edge
        for (int n = 0; n < 8; n++) begin
            step("ramp", 1'b1, 1'b0, 24'h004000);
            if (n == 3) check("ramp_first", obs(1), {2'b10, 8'h0, 16'h4000});
            if (n == 6) check("ramp_wrap", obs(1), {2'b11, 8'h0, 16'h0000});
        end

        // full carry ripple across all segments
        step("clr_a", 1'b1, 1'b1, 24'h0);
        step("ripple", 1'b1, 1'b0, 24'h00FFFF);
        step("ripple", 1'b1, 1'b0, 24'h000001);
        step("ripple", 1'b1, 1'b0, 24'h0);
        step("ripple", 1'b1, 1'b0, 24'h0);
        check("ripple_ffff", obs(1), {2'b10, 8'h0, 16'hFFFF});
        step("ripple", 1'b1, 1'b0, 24'h0);
        check("ripple_wrap", obs(1), {2'b11, 8'h0, 16'h0000});

        // enable gap: outputs frozen, no lost or repeated samples
        step("clr_b", 1'b0, 1'b1, 24'h0);
        for (int n = 0; n < 3; n++) step("gap_pre", 1'b1, 1'b0, 24'h1);
        for (int n = 0; n < 5; n++) step("gap", 1'b0, 1'b0, 24'h1);
        for (int n = 0; n < 5; n++) step("gap_post", 1'b1, 1'b0, 24'h1);
        check("gap_seq", obs(1), {2'b10, 8'h0, 16'h0005});

        // clear with samples in flight
        for (int n = 0; n < 6; n++) step("pre_clr", 1'b1, 1'b0, 24'($urandom));
        step("clr_mid", 1'b1, 1'b1, 24'h123456);
        check("clr_mid_zero", obs(1), 26'h0);
        for (int n = 0; n < 6; n++) step("post_clr", 1'b1, 1'b0, 24'h000100);

        // asynchronous reset between edges
        for (int n = 0; n < 5; n++) step("pre_rst", 1'b1, 1'b0, 24'($urandom));
        async_reset("async_rst");
        for (int n = 0; n < 6; n++) step("post_rst", 1'b1, 1'b0, 24'h000003);

        // random increments with ~70% enable duty on all widths
        for (int n = 0; n < 10000; n++) begin
            en = ($urandom_range(0, 9) < 7);
            step("rand", en, 1'b0, 24'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
